// File: rtl/palette_loader.sv
// palette_loader: streams 8-bit R,G,B bytes from the ioctl download channel
// into the palette RAM write port, one strobe per assembled 24-bit colour.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no palette download; waiting for act
// COLLECT | accepting bytes, assembling the current R,G,B triplet
// WRITE   | one-cycle palette RAM strobe; host held off with ioctl_wait
module palette_loader #(
  parameter logic [7:0] PAL_INDEX  = 8'h02,
  parameter int         NUM_COLORS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        load_color,
  output logic [5:0]  load_color_index,
  output logic [23:0] load_color_data,
  output logic        busy,
  output logic        pal_valid,
  output logic        seq_err
);

  localparam logic [7:0] BYTE_LIMIT = 8'(3 * NUM_COLORS);
  localparam logic [6:0] COLOR_MAX  = 7'(NUM_COLORS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        act;
  logic [7:0]  byte_cnt;
  logic [6:0]  color_cnt;
  logic [1:0]  phase;
  logic [7:0]  r_q, g_q;
  logic        start_dl;
  logic        end_dl;
  logic        take_byte;
  logic        drop_byte;

  assign act = ioctl_download && (ioctl_index == PAL_INDEX);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and the strobes/controls derived from the current state.
  always_comb begin
    state_nxt  = state;
    load_color = 1'b0;
    ioctl_wait = 1'b0;
    start_dl   = 1'b0;
    end_dl     = 1'b0;
    take_byte  = 1'b0;
    drop_byte  = 1'b0;
    case (state)
      IDLE: begin
        if (act) begin
          start_dl  = 1'b1;
          state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        if (!act) begin
          end_dl    = 1'b1;
          state_nxt = IDLE;
        end else if (ioctl_wr && (byte_cnt < BYTE_LIMIT)) begin
          // Bytes past the 64-entry limit (extended .pal files) fall through silently.
          take_byte = 1'b1;
          if (phase == 2'd2) state_nxt = WRITE;
        end
      end
      WRITE: begin
        load_color = 1'b1;
        ioctl_wait = 1'b1;
        drop_byte  = ioctl_wr;
        // A falling act is handled from COLLECT next cycle so the commit finishes first.
        state_nxt  = COLLECT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Byte assembly, counters and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt         <= 8'd0;
      color_cnt        <= 7'd0;
      phase            <= 2'd0;
      r_q              <= 8'd0;
      g_q              <= 8'd0;
      load_color_index <= 6'd0;
      load_color_data  <= 24'h000000;
      busy             <= 1'b0;
      pal_valid        <= 1'b0;
      seq_err          <= 1'b0;
    end else begin
      if (start_dl) begin
        byte_cnt  <= 8'd0;
        color_cnt <= 7'd0;
        phase     <= 2'd0;
        seq_err   <= 1'b0;
        pal_valid <= 1'b0;
        busy      <= 1'b1;
      end
      if (end_dl) begin
        // A trailing partial triplet is simply never committed.
        busy      <= 1'b0;
        pal_valid <= (color_cnt == COLOR_MAX);
      end
      if (take_byte) begin
        byte_cnt <= byte_cnt + 8'd1;
        // Out-of-order addresses are flagged but the byte is still used in arrival order.
        if (ioctl_addr != {17'd0, byte_cnt}) seq_err <= 1'b1;
        case (phase)
          2'd0: r_q <= ioctl_dout;
          2'd1: g_q <= ioctl_dout;
          default: begin
            load_color_data  <= {r_q, g_q, ioctl_dout};
            load_color_index <= color_cnt[5:0];
          end
        endcase
        phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
      end
      if (drop_byte) seq_err <= 1'b1;
      if ((state == WRITE) && (color_cnt != COLOR_MAX)) color_cnt <= color_cnt + 7'd1;
    end
  end

endmodule

// File: doc/palette_loader.md
# palette_loader

Streams a user palette file (.pal, 8-bit R,G,B triplets) from the HPS ioctl download channel into the video block's palette RAM write port (`load_color`, `load_color_index`, `load_color_data`). It is the writer side of that port: it assembles bytes into 24-bit entries, issues one write strobe per colour, throttles the host with `ioctl_wait` during each commit, and reports when a complete 64-entry palette has been loaded. It sits in the top level between the HPS I/O block and the video block.

## Interface
Parameters:
- `PAL_INDEX`, default 8'h02: `ioctl_index` value that identifies a palette download.
- `NUM_COLORS`, default 64: entries per palette. This value is fixed, and the byte limit is 3*NUM_COLORS = 192.

Ports:
- `clk`  in  1  system clock. One clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `ioctl_download`  in  1  download active.
- `ioctl_index`  in  8  download file type.
- `ioctl_wr`  in  1  byte write strobe, one cycle.
- `ioctl_addr`  in  25  byte address of `ioctl_dout`.
- `ioctl_dout`  in  8  download byte.
- `ioctl_wait`  out  1  host must not issue `ioctl_wr` while this is high.
- `load_color`  out  1  palette RAM write strobe, one-cycle pulse.
- `load_color_index`  out  6  palette entry being written.
- `load_color_data`  out  24  {R,G,B} for that entry.
- `busy`  out  1  a palette download is in progress.
- `pal_valid`  out  1  the last download delivered all 64 entries.
- `seq_err`  out  1  sticky flag: out-of-order address or a write while waiting.

## Operation
- A download is active when `act = ioctl_download && ioctl_index == PAL_INDEX`.
- State machine states:
  - IDLE:
    - If `act` is high: clear `byte_cnt`, `color_cnt`, `phase`, `seq_err` and `pal_valid`, set `busy`, and go to COLLECT.
  - COLLECT:
    - On `ioctl_wr` with `byte_cnt < 192`:
      - Store `ioctl_dout` into R, G or B according to `phase` (0, 1, 2).
      - Increment `byte_cnt`.
      - If `ioctl_addr != byte_cnt`, set `seq_err`. The byte is still stored in sequence.
      - On `phase == 2`: latch {R,G,B} into `load_color_data`, latch `color_cnt` into `load_color_index`, set `phase = 0`, and go to WRITE.
      - Otherwise, increment `phase`.
    - On `ioctl_wr` with `byte_cnt >= 192`: ignore the byte. This covers extended 1536-byte .pal files with emphasis tables. `seq_err` is not set.
    - When `act` falls: go to IDLE, clear `busy`, and set `pal_valid = (color_cnt == 64)`. Any partial triplet is discarded.
  - WRITE (one cycle):
    - `load_color = 1` and `ioctl_wait = 1`.
    - Increment `color_cnt` (7 bits, saturating at 64).
    - Return to COLLECT.
    - An `ioctl_wr` arriving in this cycle is dropped and sets `seq_err`.
    - If `act` falls in this cycle, the write still completes. The IDLE transition is taken next cycle with the updated `color_cnt`.
- `load_color_index` and `load_color_data` hold their last values outside WRITE.
- The palette RAM is never rolled back. A partial load leaves entries `0..color_cnt-1` overwritten with `pal_valid = 0`.
- `reset` takes priority over all of the above in any state:
  - All outputs and internal registers return to their reset values and the state goes to IDLE.
  - The download is abandoned. The block does not re-arm until `act` is seen high in IDLE.
- A download with a different `ioctl_index` is ignored entirely, and `pal_valid` is not affected by it.

## Timing
- Reset values: `ioctl_wait`, `load_color`, `busy`, `pal_valid` and `seq_err` are 0; `load_color_index` is 0; `load_color_data` is 24'h000000; state is IDLE.
- `busy` rises 1 cycle after `act` rises.
- For the B byte of colour n accepted at cycle t:
  - `load_color` and `ioctl_wait` are high at cycle t+1 only.
  - In that cycle, `load_color_index = n` and `load_color_data = {R,G,B}`.
- Throughput is limited only by the host. Minimum spacing between `ioctl_wr` pulses is 1 cycle, except that the cycle after each B byte is blocked by `ioctl_wait`.
- `pal_valid` and the fall of `busy` occur 1 cycle after `act` falls, or 2 cycles if `act` falls during WRITE.
- `load_color` is never high for 2 consecutive cycles.

## Test plan
- Full 192-byte download with byte k = k, addresses in order:
  - 64 `load_color` pulses.
  - Entry 0 = 24'h000102; entry 63 = 24'hBDBEBF.
  - `pal_valid = 1`, `seq_err = 0`, `busy` low 1 cycle after `ioctl_download` falls.
- 1536-byte download:
  - Exactly 64 pulses.
  - Bytes 192..1535 produce no strobe.
  - `pal_valid = 1`.
- Download of 100 bytes:
  - 33 pulses, indices 0..32.
  - The trailing R byte is discarded.
  - `pal_valid = 0`.
- `ioctl_wr` driven in the `ioctl_wait` cycle after byte 2:
  - The byte is dropped and `seq_err = 1`.
  - The next accepted byte becomes the R of entry 1.
- Download with `ioctl_index = 8'h01`: no pulses, `busy` stays 0, and a prior `pal_valid = 1` is retained.
- `reset` asserted after byte 50, then a fresh full download:
  - All outputs are 0 the cycle after reset.
  - The new download starts at index 0 and ends with `pal_valid = 1`.
